// File: rtl/mmio_gpio_pkg.sv
// Shared register-map constants and types for the memory-mapped GPIO block.
package mmio_gpio_pkg;

  localparam int GPIO_OFS_OUT      = 0;
  localparam int GPIO_OFS_IN       = 1;
  localparam int GPIO_OFS_EDGE     = 2;
  localparam int GPIO_OFS_IRQ_MASK = 3;

  typedef enum logic [1:0] {
    REG_OUT      = 2'(GPIO_OFS_OUT),
    REG_IN       = 2'(GPIO_OFS_IN),
    REG_EDGE     = 2'(GPIO_OFS_EDGE),
    REG_IRQ_MASK = 2'(GPIO_OFS_IRQ_MASK)
  } gpio_reg_e;

endpackage

// File: rtl/gpio_debounce.sv
// One input bit: optional polarity invert, 2-flop synchroniser, debounce counter.
// rise pulses on the same clock edge that stable goes 0->1.
module gpio_debounce #(
  parameter bit IN_ACTIVE_LOW   = 1'b1,
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;
  logic          accept;

  assign accept = (sync != stable) && (cnt == CNT_LAST);
  assign rise   = accept && sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      meta <= raw ^ IN_ACTIVE_LOW;
      sync <= meta;
      // Any return to the stable level restarts the count, so short bounces vanish.
      if (sync == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: OUT / IN / EDGE (W1C) / IRQ_MASK at BASE_ADDR+0..3.
// Define GPIO_IRQ_EN to build the mask register and the level interrupt.
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDR       = 32'h0000007A,
  parameter int               OUT_W           = 6,
  parameter int               IN_W            = 1,
  parameter logic [OUT_W-1:0] OUT_RESET       = {OUT_W{1'b1}},
  parameter bit               IN_ACTIVE_LOW   = 1'b1,
  parameter int               DEBOUNCE_CYCLES = 270000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      write_data,
  input  logic             mem_write,
  input  logic             mem_read,
  output logic [31:0]      read_data,
  input  logic [IN_W-1:0]  i_gpio,
  output logic [OUT_W-1:0] o_gpio,
  output logic             o_irq
);

  logic [31:0]     off;
  logic            hit;
  logic            we;
  gpio_reg_e       sel;
  logic [IN_W-1:0] in_stable;
  logic [IN_W-1:0] in_rise;
  logic [IN_W-1:0] edge_q;
  logic [IN_W-1:0] edge_nxt;
  logic [IN_W-1:0] edge_clr;
  logic            unused;

  assign off = addr - BASE_ADDR;
  assign hit = (off[31:2] == '0);
  assign sel = gpio_reg_e'(off[1:0]);
  assign we  = mem_write && hit;
  assign unused = ^write_data;

  for (genvar i = 0; i < IN_W; i++) begin : g_in
    gpio_debounce #(
      .IN_ACTIVE_LOW  (IN_ACTIVE_LOW),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (i_gpio[i]),
      .stable(in_stable[i]),
      .rise  (in_rise[i])
    );
  end

  // Set wins over a simultaneous write-1-to-clear.
  assign edge_clr = (we && sel == REG_EDGE) ? write_data[IN_W-1:0] : '0;
  assign edge_nxt = (edge_q & ~edge_clr) | in_rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_gpio <= OUT_RESET;
      edge_q <= '0;
    end else begin
      if (we && sel == REG_OUT) o_gpio <= write_data[OUT_W-1:0];
      edge_q <= edge_nxt;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [IN_W-1:0] mask_q;
  logic [IN_W-1:0] mask_nxt;
  logic            irq_q;

  assign mask_nxt = (we && sel == REG_IRQ_MASK) ? write_data[IN_W-1:0] : mask_q;

  // Registered from next-state so the pin changes together with EDGE/IRQ_MASK.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_nxt;
      irq_q  <= |(edge_nxt & mask_nxt);
    end
  end

  assign o_irq = irq_q;
`else
  assign o_irq = 1'b0;
`endif

  always_comb begin
    read_data = '0;
    if (mem_read && hit) begin
      case (sel)
        REG_OUT:  read_data[OUT_W-1:0] = o_gpio;
        REG_IN:   read_data[IN_W-1:0]  = in_stable;
        REG_EDGE: read_data[IN_W-1:0]  = edge_q;
`ifdef GPIO_IRQ_EN
        REG_IRQ_MASK: read_data[IN_W-1:0] = mask_q;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_gpio.sv
// Scoreboard bench for mmio_gpio (DEBOUNCE_CYCLES=4, IN_W=2, OUT_W=6).
module tb_mmio_gpio;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  localparam int K_RD  = 0;
  localparam int K_OUT = 1;
  localparam int K_IRQ = 2;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] write_data = '0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] read_data;
  logic [1:0]  i_gpio = 2'b11;
  logic [5:0]  o_gpio;
  logic        o_irq;
  logic        chk = 1'b0;

  chk_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  mmio_gpio #(
    .OUT_W(6), .IN_W(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .write_data(write_data),
    .mem_write(mem_write), .mem_read(mem_read), .read_data(read_data),
    .i_gpio(i_gpio), .o_gpio(o_gpio), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  // Monitor: drains every pending expectation whenever a read or probe is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_read || chk) begin
        while (q.size() > 0) begin
          chk_t c;
          logic [31:0] act;
          c = q.pop_front();
          case (c.kind)
            K_RD:    act = read_data;
            K_OUT:   act = {26'b0, o_gpio};
            default: act = {31'b0, o_irq};
          endcase
          n_total++;
          if (act === c.exp) n_pass++;
          else $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, act, c.exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; write_data = d; mem_write = 1'b1;
    tick(1);
    mem_write = 1'b0; addr = '0; write_data = '0;
  endtask

  // Read without consuming a clock edge when issued right after tick().
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm,
                    input bit with_irq = 1'b0, input bit irq_e = 1'b0);
    addr = a; mem_read = 1'b1;
    q.push_back('{nm, K_RD, e});
    if (with_irq) q.push_back('{{nm, "_irq"}, K_IRQ, {31'b0, irq_e}});
    @(negedge clk); #1;
    mem_read = 1'b0; addr = '0;
  endtask

  task automatic probe(input int k, input logic [31:0] e, input string nm);
    q.push_back('{nm, k, e});
    chk = 1'b1;
    @(negedge clk); #1;
    chk = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    reset = 1'b0;
    probe(K_OUT, 32'h3F, "rst_o_gpio");
    probe(K_IRQ, 32'h0, "rst_o_irq");
    tick(1);
    rd(32'h7A, 32'h3F, "rst_out");
    tick(1); rd(32'h7B, 32'h0, "rst_in");
    tick(1); rd(32'h7C, 32'h0, "rst_edge");
    tick(1); rd(32'h7D, 32'h0, "rst_mask");

    // Output register, read-only IN, decode misses
    tick(1);
    wr(32'h7A, 32'hFFFF_FF15);
    probe(K_OUT, 32'h15, "out_pin");
    tick(1); rd(32'h7A, 32'h15, "out_read");
    tick(1); wr(32'h7B, 32'h3);
    rd(32'h7B, 32'h0, "in_write_ignored");
    tick(1); rd(32'h79, 32'h0, "miss_below");
    tick(1); rd(32'h7E, 32'h0, "miss_above");
    tick(1); addr = 32'h7A; probe(K_RD, 32'h0, "no_mem_read"); addr = '0;
    tick(1); wr(32'h7E, 32'h0); probe(K_OUT, 32'h15, "miss_write");
    tick(1); wr(32'h7D, 32'h1);
    rd(32'h7D, IRQ ? 32'h1 : 32'h0, "mask_read");

    // Bounce of 3 cycles is rejected
    tick(1);
    i_gpio[0] = 1'b0; tick(3);
    i_gpio[0] = 1'b1; tick(8);
    rd(32'h7B, 32'h0, "bounce_in");
    tick(1); rd(32'h7C, 32'h0, "bounce_edge");

    // Held press: accepted on the 6th edge, edge flag on the same cycle
    tick(1);
    i_gpio[0] = 1'b0; tick(5);
    rd(32'h7C, 32'h0, "press_edge_early", 1'b1, 1'b0);
    tick(1);
    rd(32'h7C, 32'h1, "press_edge", 1'b1, IRQ);
    rd(32'h7B, 32'h1, "press_in");

    // Set on bit 1 lands with a W1C of bit 0
    tick(1);
    i_gpio[1] = 1'b0; tick(5);
    wr(32'h7C, 32'h1);
    rd(32'h7C, 32'h2, "race_edge", 1'b1, 1'b0);
    rd(32'h7B, 32'h3, "race_in");
    tick(1); wr(32'h7D, 32'h3);
    rd(32'h7D, IRQ ? 32'h3 : 32'h0, "mask3", 1'b1, IRQ);
    tick(1); wr(32'h7C, 32'h2);
    rd(32'h7C, 32'h0, "w1c_all", 1'b1, 1'b0);

    // Reset mid-debounce discards the pending change
    tick(1);
    i_gpio = 2'b11; tick(8);
    rd(32'h7B, 32'h0, "release_in");
    tick(1); rd(32'h7C, 32'h0, "release_edge");
    tick(1);
    i_gpio[0] = 1'b0; tick(4);
    reset = 1'b1; tick(1); reset = 1'b0;
    probe(K_OUT, 32'h3F, "midrst_o_gpio");
    tick(5);
    rd(32'h7B, 32'h0, "midrst_in_early");
    tick(1);
    rd(32'h7B, 32'h1, "midrst_in");
    rd(32'h7C, 32'h1, "midrst_edge", 1'b1, 1'b0);

    tick(2);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
